uart_cmd_master: RTL and testbench

- Host-side initiator for the board's ASCII UART register/ALU command protocol. It is the other end of the FPGA command parser.
- Takes one parallel request, serializes it into ASCII command bytes on a byte-level UART TX handshake, then parses the slave's reply into data and flags.
- Used in loopback/self-test builds and to let one board drive another over UART.

---
 rtl/uart_cmd_master_if.sv | 36 +++
 rtl/uart_cmd_master.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_master_if.sv
// Request, UART byte-stream and response signals of uart_cmd_master.
// master: the command initiator; slave: the requester/UART side.
interface uart_cmd_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [15:0] req_a1;
    logic [15:0] req_a2;
    logic [15:0] req_dst;
    logic [15:0] req_wdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    modport master (
        input  req_valid, req_cmd, req_a1, req_a2, req_dst, req_wdata,
               tx_busy, rx_data, rx_valid,
        output req_ready, tx_data, tx_start,
               rsp_valid, rsp_data, rsp_flags, rsp_err, cnt_ok, cnt_err
    );

    modport slave (
        output req_valid, req_cmd, req_a1, req_a2, req_dst, req_wdata,
               tx_busy, rx_data, rx_valid,
        input  req_ready, tx_data, tx_start,
               rsp_valid, rsp_data, rsp_flags, rsp_err, cnt_ok, cnt_err
    );
endinterface

// File: rtl/uart_cmd_master.sv
// Host-side ASCII UART command initiator: serializes one request, parses the reply.
// Optional UART_CMD_MASTER_STATS_EN builds saturating ok/err completion counters.
module uart_cmd_master #(
    parameter int unsigned ADDR_DIGITS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_master_if.master bus
);

    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  AD_LAST = 2'(ADDR_DIGITS - 1);

    localparam logic [2:0] CMD_S = 3'd0;
    localparam logic [2:0] CMD_U = 3'd1;
    localparam logic [2:0] CMD_N = 3'd2;
    localparam logic [2:0] CMD_O = 3'd3;
    localparam logic [2:0] CMD_X = 3'd4;
    localparam logic [2:0] CMD_T = 3'd5;
    localparam logic [2:0] CMD_W = 3'd6;
    localparam logic [2:0] CMD_R = 3'd7;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_D    = 8'h64;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] dst;
        logic [15:0] wdata;
    } req_t;

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT, TX_DONE} tx_state_e;

    typedef enum logic [2:0] {
        SEG_LET, SEG_A1, SEG_SP1, SEG_F2, SEG_SP2, SEG_F3, SEG_CR
    } seg_e;

    typedef enum logic [3:0] {
        RX_IDLE, RX_HASH, RX_D, RX_SP1, RX_DIG, RX_SP2,
        RX_FLAG_L, RX_FLAG_B, RX_LF, RX_DISCARD, RX_DONE
    } rx_state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Digit k (0 = most significant) of a field that is ndig+1 digits wide.
    function automatic logic [3:0] pick_nib(input logic [15:0] v, input logic [1:0] ndig,
                                            input logic [1:0] k);
        logic [1:0] pos;
        pos = ndig - k;
        return 4'(v >> {pos, 2'b00});
    endfunction

    function automatic logic [7:0] cmd_letter(input logic [2:0] c);
        case (c)
            CMD_S:   return 8'h53;
            CMD_U:   return 8'h55;
            CMD_N:   return 8'h4E;
            CMD_O:   return 8'h4F;
            CMD_X:   return 8'h58;
            CMD_T:   return 8'h54;
            CMD_W:   return 8'h57;
            default: return 8'h52;
        endcase
    endfunction

    // {valid, value} of an ASCII hex digit, either case.
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        return 5'd0;
    endfunction

    function automatic logic [7:0] flag_letter(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h5A;
            2'd1:    return 8'h53;
            2'd2:    return 8'h43;
            default: return 8'h56;
        endcase
    endfunction

    req_t              req_q, req_d;
    tx_state_e         tx_state_q, tx_state_d;
    seg_e              seg_q, seg_d, seg_nx;
    logic [1:0]        dig_q, dig_d, dig_nx;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              req_ready_q, req_ready_d;
    logic              abort_q, abort_d;
    rx_state_e         rx_state_q, rx_state_d;
    logic [1:0]        rdig_q, rdig_d;
    logic [1:0]        fidx_q, fidx_d;
    logic [15:0]       acc_data_q, acc_data_d;
    logic [3:0]        acc_flags_q, acc_flags_d;
    logic              acc_err_q, acc_err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept_c;
    logic              rx_active_c;
    logic              timeout_c;
    logic              done_c;
    logic              last_byte_c;
    logic [1:0]        f2_last_c;
    logic [7:0]        cur_byte_c;
    logic [4:0]        hex_c;
    logic              byte_ok_c;

    assign accept_c    = bus.req_valid && req_ready_q;
    assign rx_active_c = (rx_state_q != RX_IDLE) && (rx_state_q != RX_DONE);
    assign timeout_c   = rx_active_c && !bus.rx_valid && (to_cnt_q == TO_LAST);
    assign done_c      = (tx_state_q == TX_DONE) && (rx_state_q == RX_DONE);
    assign hex_c       = hex_val(bus.rx_data);

    // Current TX byte and the position of the byte after it.
    always_comb begin
        f2_last_c   = (req_q.cmd == CMD_W) ? 2'd3 : AD_LAST;
        last_byte_c = (seg_q == SEG_CR);
        seg_nx      = seg_q;
        dig_nx      = dig_q;
        case (seg_q)
            SEG_LET: cur_byte_c = cmd_letter(req_q.cmd);
            SEG_A1:  cur_byte_c = hex_char(pick_nib(req_q.a1, AD_LAST, dig_q));
            SEG_F2:  cur_byte_c = hex_char(pick_nib((req_q.cmd == CMD_W) ? req_q.wdata : req_q.a2,
                                                    f2_last_c, dig_q));
            SEG_F3:  cur_byte_c = hex_char(pick_nib(req_q.dst, AD_LAST, dig_q));
            SEG_CR:  cur_byte_c = CH_CR;
            default: cur_byte_c = CH_SP;
        endcase
        case (seg_q)
            SEG_LET: begin
                seg_nx = SEG_A1;
                dig_nx = 2'd0;
            end
            SEG_A1: begin
                if (dig_q == AD_LAST) begin
                    seg_nx = (req_q.cmd == CMD_R) ? SEG_CR : SEG_SP1;
                    dig_nx = 2'd0;
                end else begin
                    dig_nx = dig_q + 2'd1;
                end
            end
            SEG_SP1: seg_nx = SEG_F2;
            SEG_F2: begin
                if (dig_q == f2_last_c) begin
                    seg_nx = (req_q.cmd == CMD_W || req_q.cmd == CMD_T) ? SEG_CR : SEG_SP2;
                    dig_nx = 2'd0;
                end else begin
                    dig_nx = dig_q + 2'd1;
                end
            end
            SEG_SP2: seg_nx = SEG_F3;
            SEG_F3: begin
                if (dig_q == AD_LAST) begin
                    seg_nx = SEG_CR;
                    dig_nx = 2'd0;
                end else begin
                    dig_nx = dig_q + 2'd1;
                end
            end
            default: seg_nx = SEG_CR;
        endcase
    end

    // TX FSM: one start pulse per byte, next byte only after an idle, non-busy cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        seg_d      = seg_q;
        dig_d      = dig_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        req_d      = req_q;
        abort_d    = abort_q;
        if (accept_c)       abort_d = 1'b0;
        else if (timeout_c) abort_d = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (accept_c) begin
                    req_d.cmd   = bus.req_cmd;
                    req_d.a1    = bus.req_a1;
                    req_d.a2    = bus.req_a2;
                    req_d.dst   = bus.req_dst;
                    req_d.wdata = bus.req_wdata;
                    seg_d       = SEG_LET;
                    dig_d       = 2'd0;
                    tx_state_d  = TX_SEND;
                end
            end
            TX_SEND: begin
                if (abort_q || timeout_c) begin
                    tx_state_d = TX_DONE;
                end else begin
                    tx_data_d  = cur_byte_c;
                    tx_start_d = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!bus.tx_busy && !tx_start_q) begin
                    if (last_byte_c || abort_q || timeout_c) begin
                        tx_state_d = TX_DONE;
                    end else begin
                        seg_d      = seg_nx;
                        dig_d      = dig_nx;
                        tx_state_d = TX_SEND;
                    end
                end
            end
            TX_DONE: begin
                if (done_c) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX parser and inter-byte timeout; a bad byte poisons the reply until LF.
    always_comb begin
        rx_state_d  = rx_state_q;
        rdig_d      = rdig_q;
        fidx_d      = fidx_q;
        acc_data_d  = acc_data_q;
        acc_flags_d = acc_flags_q;
        acc_err_d   = acc_err_q;
        to_cnt_d    = to_cnt_q;
        byte_ok_c   = 1'b0;
        if (accept_c) begin
            rx_state_d  = RX_HASH;
            rdig_d      = 2'd0;
            fidx_d      = 2'd0;
            acc_data_d  = 16'h0000;
            acc_flags_d = 4'h0;
            acc_err_d   = 1'b0;
            to_cnt_d    = '0;
        end else if (rx_active_c) begin
            if (bus.rx_valid) begin
                to_cnt_d = '0;
                case (rx_state_q)
                    RX_HASH: begin
                        if (bus.rx_data == CH_HASH) begin
                            byte_ok_c = 1'b1;
                            if (req_q.cmd == CMD_W) begin
                                acc_data_d = req_q.wdata;
                                rx_state_d = RX_DONE;
                            end else begin
                                rx_state_d = RX_D;
                            end
                        end
                    end
                    RX_D: begin
                        if (bus.rx_data == CH_D) begin
                            byte_ok_c  = 1'b1;
                            rx_state_d = RX_SP1;
                        end
                    end
                    RX_SP1: begin
                        if (bus.rx_data == CH_SP) begin
                            byte_ok_c  = 1'b1;
                            rdig_d     = 2'd0;
                            rx_state_d = RX_DIG;
                        end
                    end
                    RX_DIG: begin
                        if (hex_c[4]) begin
                            byte_ok_c  = 1'b1;
                            acc_data_d = {acc_data_q[11:0], hex_c[3:0]};
                            rdig_d     = rdig_q + 2'd1;
                            if (rdig_q == 2'd3) rx_state_d = RX_SP2;
                        end
                    end
                    RX_SP2: begin
                        if (bus.rx_data == CH_SP) begin
                            byte_ok_c  = 1'b1;
                            fidx_d     = 2'd0;
                            rx_state_d = RX_FLAG_L;
                        end
                    end
                    RX_FLAG_L: begin
                        if (bus.rx_data == flag_letter(fidx_q)) begin
                            byte_ok_c  = 1'b1;
                            rx_state_d = RX_FLAG_B;
                        end
                    end
                    RX_FLAG_B: begin
                        if (bus.rx_data == CH_0 || bus.rx_data == CH_1) begin
                            byte_ok_c   = 1'b1;
                            acc_flags_d = {acc_flags_q[2:0], bus.rx_data[0]};
                            fidx_d      = fidx_q + 2'd1;
                            rx_state_d  = (fidx_q == 2'd3) ? RX_LF : RX_FLAG_L;
                        end
                    end
                    RX_LF: begin
                        if (bus.rx_data == CH_LF) begin
                            byte_ok_c  = 1'b1;
                            rx_state_d = RX_DONE;
                        end
                    end
                    RX_DISCARD: begin
                        byte_ok_c = 1'b1;
                        if (bus.rx_data == CH_LF) rx_state_d = RX_DONE;
                    end
                    default: byte_ok_c = 1'b1;
                endcase
                if (!byte_ok_c) begin
                    acc_err_d  = 1'b1;
                    rx_state_d = (bus.rx_data == CH_LF) ? RX_DONE : RX_DISCARD;
                end
            end else if (timeout_c) begin
                acc_err_d  = 1'b1;
                rx_state_d = RX_DONE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else if (done_c) begin
            rx_state_d = RX_IDLE;
        end
    end

    // Completion: publish the parsed reply; req_ready rises the cycle after rsp_valid.
    always_comb begin
        rsp_valid_d = done_c;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        if (done_c) begin
            rsp_data_d  = acc_data_q;
            rsp_flags_d = acc_flags_q;
            rsp_err_d   = acc_err_q;
        end
        req_ready_d = (tx_state_d == TX_IDLE) && !done_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            tx_state_q  <= TX_IDLE;
            seg_q       <= SEG_LET;
            dig_q       <= 2'd0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            req_ready_q <= 1'b1;
            abort_q     <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rdig_q      <= 2'd0;
            fidx_q      <= 2'd0;
            acc_data_q  <= 16'h0000;
            acc_flags_q <= 4'h0;
            acc_err_q   <= 1'b0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_flags_q <= 4'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_q       <= req_d;
            tx_state_q  <= tx_state_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            abort_q     <= abort_d;
            rx_state_q  <= rx_state_d;
            rdig_q      <= rdig_d;
            fidx_q      <= fidx_d;
            acc_data_q  <= acc_data_d;
            acc_flags_q <= acc_flags_d;
            acc_err_q   <= acc_err_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef UART_CMD_MASTER_STATS_EN
    logic [15:0] cnt_ok_q, cnt_ok_d;
    logic [15:0] cnt_err_q, cnt_err_d;

    // Saturating completion counters.
    always_comb begin
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (rsp_valid_q && !rsp_err_q && cnt_ok_q != 16'hFFFF)  cnt_ok_d  = cnt_ok_q + 16'd1;
        if (rsp_valid_q && rsp_err_q && cnt_err_q != 16'hFFFF)  cnt_err_d = cnt_err_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok_q  <= 16'h0000;
            cnt_err_q <= 16'h0000;
        end else begin
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign bus.cnt_ok  = cnt_ok_q;
    assign bus.cnt_err = cnt_err_q;
`else
    assign bus.cnt_ok  = 16'h0000;
    assign bus.cnt_err = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: expected TX bytes and responses are queued
// at issue time and popped by independent TX and response monitors.
`timescale 1ns/1ps
module tb_uart_cmd_master;

    localparam int unsigned TO = 100;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
        bit          chk;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_master_if bus();

    uart_cmd_master #(.ADDR_DIGITS(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tx_seen = 0;
    int          rsp_seen = 0;
    int          busy_cnt;
    bit          prev_idle = 1'b1;
    logic [7:0]  tx_q[$];
    rsp_t        rsp_q[$];
    rsp_t        mon_r;
    logic [7:0]  mon_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Transmitter model: busy for four cycles after each start pulse.
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (bus.tx_start)  busy_cnt <= 4;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // TX monitor: byte order and the idle-cycle rule between start pulses.
    always @(negedge clk) begin
        if (!rst && bus.tx_start) begin
            tx_seen++;
            if (tx_q.size() == 0) begin
                fail_now("tx_unexpected", 32'(bus.tx_data), 0);
            end else begin
                mon_b = tx_q.pop_front();
                chk("tx_byte", 32'(bus.tx_data), 32'(mon_b));
            end
            chk("tx_gap", 32'(prev_idle), 32'd1);
        end
        prev_idle = !bus.tx_busy && !bus.tx_start;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                fail_now("rsp_unexpected", 32'(bus.rsp_data), 0);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
                if (mon_r.chk) begin
                    chk("rsp_data", 32'(bus.rsp_data), 32'(mon_r.data));
                    chk("rsp_flags", 32'(bus.rsp_flags), 32'(mon_r.flags));
                end
            end
            rsp_seen++;
        end
    end

    task automatic expect_rsp(input logic [15:0] d, input logic [3:0] f, input logic e, input bit c);
        rsp_t r;
        r.data = d; r.flags = f; r.err = e; r.chk = c;
        rsp_q.push_back(r);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [15:0] dst, input logic [15:0] wd, input string txs);
        for (int i = 0; i < txs.len(); i++) tx_q.push_back(txs[i]);
        tx_q.push_back(8'h0D);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_cmd = cmd; bus.req_a1 = a1; bus.req_a2 = a2;
        bus.req_dst = dst; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b; bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_rx(s[i]);
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (tx_seen < n && c < 1000) begin @(posedge clk); c++; end
        if (tx_seen < n) fail_now("tx_wait_timeout", tx_seen, n);
    endtask

    task automatic wait_rsp(input int base, output int lat);
        lat = 0;
        while (rsp_seen == base && lat < 1000) begin @(posedge clk); lat++; end
        if (rsp_seen == base) begin
            fail_now("rsp_wait_timeout", lat, 1000);
        end else begin
            @(negedge clk);
            chk("ready_after_rsp", 32'(bus.req_ready), 32'd1);
            chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        end
        chk("tx_all_sent", 32'(tx_q.size()), 32'd0);
    endtask

    task automatic check_stats(input int ok, input int er);
`ifdef UART_CMD_MASTER_STATS_EN
        chk("cnt_ok", 32'(bus.cnt_ok), 32'(ok));
        chk("cnt_err", 32'(bus.cnt_err), 32'(er));
`else
        chk("cnt_ok", 32'(bus.cnt_ok), 32'(ok - ok));
        chk("cnt_err", 32'(bus.cnt_err), 32'(er - er));
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tx_q.delete();
        rsp_q.delete();
        bus.rx_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_cmd = 3'd0; bus.req_a1 = 16'h0; bus.req_a2 = 16'h0;
        bus.req_dst = 16'h0; bus.req_wdata = 16'h0; bus.rx_data = 8'h0; bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_tx_start", 32'(bus.tx_start), 32'd0);
        chk("reset_tx_data", 32'(bus.tx_data), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("reset_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_stats(0, 0);
        rst = 1'b0;

        // W: completes on '#'
        base = rsp_seen;
        expect_rsp(16'hBEEF, 4'b0000, 1'b0, 1'b1);
        issue(3'd6, 16'h0012, 16'h0000, 16'h0000, 16'hBEEF, "W0012 BEEF");
        wait_tx(tx_seen + 1);
        send_rx(8'h23);
        wait_rsp(base, lat);

        // S: full reply arrives while TX runs; stray req_valid while busy is ignored
        base = rsp_seen;
        expect_rsp(16'h0005, 4'b0000, 1'b0, 1'b1);
        issue(3'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, "S0001 0002 0003");
        wait_tx(tx_seen + 1);
        send_str("#d 0005 Z0S0C0V0");
        send_rx(8'h0A);
        @(negedge clk);
        bus.req_cmd = 3'd7; bus.req_a1 = 16'hFFFF; bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(base, lat);

        // R: lowercase hex digits
        base = rsp_seen;
        expect_rsp(16'hFF00, 4'b0110, 1'b0, 1'b1);
        issue(3'd7, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, "R03FF");
        wait_tx(tx_seen + 1);
        send_str("#d ff00 Z0S1C1V0");
        send_rx(8'h0A);
        wait_rsp(base, lat);

        // Bad digit: error reported only after the trailing LF
        base = rsp_seen;
        expect_rsp(16'h0000, 4'b0000, 1'b1, 1'b0);
        issue(3'd7, 16'h0010, 16'h0000, 16'h0000, 16'h0000, "R0010");
        wait_tx(tx_seen + 1);
        send_str("#d 00G0 Z0S0C0V0");
        repeat (20) @(negedge clk);
        chk("err_waits_lf", 32'(rsp_seen), 32'(base));
        send_rx(8'h0A);
        wait_rsp(base, lat);

        // T with no reply: timeout abort
        base = rsp_seen;
        expect_rsp(16'h0000, 4'b0000, 1'b1, 1'b0);
        issue(3'd5, 16'h0004, 16'h0005, 16'h0000, 16'h0000, "T0004 0005");
        wait_rsp(base, lat);
        chk("timeout_latency", 32'(lat >= 95 && lat <= 110), 32'd1);

        // U: uppercase hex, all flags set
        base = rsp_seen;
        expect_rsp(16'hABCD, 4'b1111, 1'b0, 1'b1);
        issue(3'd1, 16'h00AB, 16'hCDEF, 16'h1234, 16'h0000, "U00AB CDEF 1234");
        wait_tx(tx_seen + 1);
        send_str("#d ABCD Z1S1C1V1");
        send_rx(8'h0A);
        wait_rsp(base, lat);
        repeat (3) @(negedge clk);
        check_stats(4, 2);

        // rx bytes while idle are ignored
        base = rsp_seen;
        send_str("#d");
        send_rx(8'h0A);
        repeat (10) @(negedge clk);
        chk("idle_rx_ignored", 32'(rsp_seen), 32'(base));
        chk("idle_ready", 32'(bus.req_ready), 32'd1);

        // Reset mid-TX
        issue(3'd2, 16'h0001, 16'h0002, 16'h0003, 16'h0000, "N0001 0002 0003");
        wait_tx(tx_seen + 3);
        pulse_reset();

        // Reset mid-parse
        issue(3'd7, 16'h0001, 16'h0000, 16'h0000, 16'h0000, "R0001");
        wait_tx(tx_seen + 1);
        send_str("#d 00");
        pulse_reset();
        base = rsp_seen;
        repeat (30) @(negedge clk);
        chk("no_rsp_after_reset", 32'(rsp_seen), 32'(base));

        // Fresh request after reset
        base = rsp_seen;
        expect_rsp(16'h1234, 4'b1011, 1'b0, 1'b1);
        issue(3'd4, 16'h000A, 16'h000B, 16'h000C, 16'h0000, "X000A 000B 000C");
        wait_tx(tx_seen + 1);
        send_str("#d 1234 Z1S0C1V1");
        send_rx(8'h0A);
        wait_rsp(base, lat);
        repeat (5) @(negedge clk);
        chk("hold_rsp_data", 32'(bus.rsp_data), 32'h1234);
        chk("hold_rsp_flags", 32'(bus.rsp_flags), 32'hB);
        chk("hold_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_stats(1, 0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
